// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   localparam int SUB_WIDTH_DEF = 8;

   function automatic int sub_cnt_w(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, the borrow twin of the full-adder cell.
module full_subtractor (
   output logic d,
   output logic bo,
   input  logic a,
   input  logic b,
   input  logic bi
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial diff = a - b - bin, LSB first, through one cell.
// Optional signed-overflow output: define SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int CW = sub_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sub_state_t       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_d;
   logic [CW-1:0]    cnt_q;
   logic             br_q;
   logic             br_d;
   logic             d_bit;
   logic             bout_q;
   logic             busy_q;
   logic             done_q;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q;
`endif

   full_subtractor u_cell (
      .d  (d_bit),
      .bo (br_d),
      .a  (a_q[0]),
      .b  (b_q[0]),
      .bi (br_q)
   );

   // Result bits enter at the MSB so bit 0 lands at diff[0] last.
   assign diff_d = {d_bit, diff_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q    <= {1'b0, a_q[WIDTH-1:1]};
               b_q    <= {1'b0, b_q[WIDTH-1:1]};
               br_q   <= br_d;
               diff_q <= diff_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q   <= (a_q[0] ^ b_q[0]) &
                             (d_bit ^ a_q[0]);
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor, WIDTH=8.
// Covers ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int W   = 8;
   localparam int LAT = W + 1;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   localparam logic [W-1:0] TA [6] = '{8'h5A, 8'h00, 8'h10, 8'h00, 8'h80, 8'h7F};
   localparam logic [W-1:0] TB [6] = '{8'h3C, 8'h01, 8'h0F, 8'h00, 8'h01, 8'hFF};
   localparam logic         TC [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic [W-1:0] TD [6] = '{8'h1E, 8'hFF, 8'h00, 8'hFF, 8'h7F, 8'h80};
   localparam logic         TO [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic         TV [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

`ifdef SERIAL_SUB_OVF_EN
   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
   );
`else
   assign ovf = 1'b0;
   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
   );
`endif

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c);
      logic [W:0] r;
      exp_t       e;
      r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
      e.diff = r[W-1:0];
      e.bout = r[W];
      e.ovf  = (x[W-1] ^ y[W-1]) & (r[W-1] ^ x[W-1]);
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic kick(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input bit push, input exp_t e);
      a = x; b = y; bin = c; start = 1'b1;
      if (push) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok, output int lat, output int nbusy);
      ok = 1'b0; lat = 1; nbusy = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
      tests++; if (diff !== '0) begin fails++; $display("FAIL rst_diff got %h want 00", diff); end
      tests++; if (bout !== 1'b0) begin fails++; $display("FAIL rst_bout got %b want 0", bout); end
      tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b want 0", ovf); end
      a = 8'h12; b = 8'h01; start = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_start_busy got %b want 0", busy); end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_wins_busy got %b want 0", busy); end
   endtask

   task automatic test_directed();
      bit   ok;
      int   lat, nb;
      exp_t e, x;
      logic [W-1:0] held;
      for (int i = 0; i < 6; i++) begin
         e.diff = TD[i]; e.bout = TO[i]; e.ovf = TV[i];
         kick(TA[i], TB[i], TC[i], 1'b1, e);
         wait_done(ok, lat, nb);
         tests++; if (!ok) begin fails++; $display("FAIL dir%0d_timeout got none want done", i); end
         tests++; if (lat !== LAT) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
         tests++; if (nb !== W) begin fails++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, nb, W); end
         tests++;
         if (sb.size() == 0) begin fails++; $display("FAIL dir%0d_sb got empty want entry", i); end
         else begin
            x = sb.pop_front();
            tests++; if (diff !== x.diff) begin fails++; $display("FAIL dir%0d_diff got %h want %h", i, diff, x.diff); end
            tests++; if (bout !== x.bout) begin fails++; $display("FAIL dir%0d_bout got %b want %b", i, bout, x.bout); end
`ifdef SERIAL_SUB_OVF_EN
            tests++; if (ovf !== x.ovf) begin fails++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf, x.ovf); end
`endif
         end
         held = diff;
         @(negedge clk);
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL dir%0d_pulse got %b want 0", i, done); end
         @(negedge clk);
         tests++; if (diff !== held) begin fails++; $display("FAIL dir%0d_hold got %h want %h", i, diff, held); end
      end
   endtask

   task automatic test_back_to_back();
      bit   ok;
      int   lat, nb;
      exp_t e, x;
      e.diff = 8'h22; e.bout = 1'b0; e.ovf = 1'b0;
      kick(8'h33, 8'h11, 1'b0, 1'b1, e);
      repeat (2) @(negedge clk);
      a = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'h00;
      wait_done(ok, lat, nb);
      tests++; if (!ok) begin fails++; $display("FAIL ign_timeout got none want done"); end
      tests++;
      if (sb.size() == 0) begin fails++; $display("FAIL ign_sb got empty want entry"); end
      else begin
         x = sb.pop_front();
         tests++; if (diff !== x.diff) begin fails++; $display("FAIL ign_diff got %h want %h", diff, x.diff); end
         tests++; if (bout !== x.bout) begin fails++; $display("FAIL ign_bout got %b want %b", bout, x.bout); end
      end
      e.diff = 8'hFE; e.bout = 1'b1; e.ovf = 1'b0;
      kick(8'h05, 8'h07, 1'b0, 1'b1, e);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", busy); end
      wait_done(ok, lat, nb);
      tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout got none want done"); end
      tests++; if (lat !== LAT) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
      tests++;
      if (sb.size() == 0) begin fails++; $display("FAIL b2b_sb got empty want entry"); end
      else begin
         x = sb.pop_front();
         tests++; if (diff !== x.diff) begin fails++; $display("FAIL b2b_diff got %h want %h", diff, x.diff); end
         tests++; if (bout !== x.bout) begin fails++; $display("FAIL b2b_bout got %b want %b", bout, x.bout); end
`ifdef SERIAL_SUB_OVF_EN
         tests++; if (ovf !== x.ovf) begin fails++; $display("FAIL b2b_ovf got %b want %b", ovf, x.ovf); end
`endif
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit   ok;
      int   lat, nb, seen;
      exp_t e, x;
      e = '0;
      kick(8'h5A, 8'h3C, 1'b0, 1'b0, e);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL mid_done got %b want 0", done); end
      tests++; if (diff !== '0) begin fails++; $display("FAIL mid_diff got %h want 00", diff); end
      tests++; if (bout !== 1'b0) begin fails++; $display("FAIL mid_bout got %b want 0", bout); end
      tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL mid_ovf got %b want 0", ovf); end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL mid_no_done got %0d want 0", seen); end
      e.diff = 8'h05; e.bout = 1'b0; e.ovf = 1'b0;
      kick(8'h09, 8'h04, 1'b0, 1'b1, e);
      wait_done(ok, lat, nb);
      tests++; if (!ok) begin fails++; $display("FAIL mid_after_timeout got none want done"); end
      tests++;
      if (sb.size() == 0) begin fails++; $display("FAIL mid_sb got empty want entry"); end
      else begin
         x = sb.pop_front();
         tests++; if (diff !== x.diff) begin fails++; $display("FAIL mid_after_diff got %h want %h", diff, x.diff); end
         tests++; if (bout !== x.bout) begin fails++; $display("FAIL mid_after_bout got %b want %b", bout, x.bout); end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      bit           ok;
      int           lat, nb;
      exp_t         x;
      logic [W-1:0] ra, rb;
      logic         rc;
      for (int i = 0; i < 8; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         kick(ra, rb, rc, 1'b1, model(ra, rb, rc));
         wait_done(ok, lat, nb);
         tests++; if (!ok) begin fails++; $display("FAIL rnd%0d_timeout got none want done", i); end
         tests++;
         if (sb.size() == 0) begin fails++; $display("FAIL rnd%0d_sb got empty want entry", i); end
         else begin
            x = sb.pop_front();
            tests++; if (diff !== x.diff) begin fails++; $display("FAIL rnd%0d_diff %h-%h-%b got %h want %h", i, ra, rb, rc, diff, x.diff); end
            tests++; if (bout !== x.bout) begin fails++; $display("FAIL rnd%0d_bout got %b want %b", i, bout, x.bout); end
`ifdef SERIAL_SUB_OVF_EN
            tests++; if (ovf !== x.ovf) begin fails++; $display("FAIL rnd%0d_ovf got %b want %b", i, ovf, x.ovf); end
`endif
         end
         if (i[0]) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
